// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_pkg: shared beat and write-FSM types for the MAC TX path.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mac_pkg;

    typedef struct packed {
        logic       tlast;
        logic [7:0] tdata;
    } axis_beat_t;

    typedef enum logic [0:0] {
        WRITE = 1'b0,
        DROP  = 1'b1
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdp_ram: simple dual-port RAM, one write port, registered read port.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sdp_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/axis_tx_frame_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_tx_frame_fifo: store-and-forward AXI-Stream frame FIFO that      |
// | releases only complete frames and drops oversize/overflowing ones.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module axis_tx_frame_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int MAX_LEN = 1500
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_axis_tvalid,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [$clog2(DEPTH):0] frame_count,
    output logic                   drop_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [PW-1:0] c_depth   = PW'(DEPTH);
    localparam logic [CW-1:0] c_max_len = CW'(MAX_LEN);

    wr_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [PW-1:0] frame_count_q;
    logic          drop_pulse_q, drop_pulse_d;

    logic          ram_vld_q;
    axis_beat_t    out_q, skid_q;
    logic          out_vld_q, skid_vld_q;

    logic          w_accept, w_full, w_wr_en, w_commit;
    logic          w_pop, w_fetch;
    logic [PW-1:0] w_used;
    logic [1:0]    w_occ;
    axis_beat_t    w_wr_beat, w_rd_beat;
    logic [8:0]    w_rd_data;

    assign w_accept  = s_axis_tvalid && !reset;
    assign w_used    = wr_ptr_q - rd_ptr_q;
    assign w_full    = (w_used == c_depth);
    assign w_wr_beat = '{tlast: s_axis_tlast, tdata: s_axis_tdata};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        byte_cnt_d   = byte_cnt_q;
        drop_pulse_d = 1'b0;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        if (w_accept) begin
            case (state_q)
                WRITE: begin
                    if (w_full || (byte_cnt_q == c_max_len)) begin
                        // A frame that overflows on its own tlast never enters DROP.
                        if (s_axis_tlast) begin
                            wr_ptr_d     = wr_commit_q;
                            drop_pulse_d = 1'b1;
                            byte_cnt_d   = '0;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        w_wr_en  = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_axis_tlast) begin
                            wr_commit_d = wr_ptr_q + 1'b1;
                            w_commit    = 1'b1;
                            byte_cnt_d  = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        wr_ptr_d     = wr_commit_q;
                        drop_pulse_d = 1'b1;
                        byte_cnt_d   = '0;
                        state_d      = WRITE;
                    end
                end
                default: state_d = WRITE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WRITE;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            byte_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            byte_cnt_q   <= byte_cnt_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Bytes held outside the RAM (in flight, output, skid) are capped at two,
    // which bounds the capacity lost to prefetch.
    assign w_pop   = out_vld_q && m_axis_tready;
    assign w_occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q} - {1'b0, w_pop};
    assign w_fetch = !reset && (rd_ptr_q != wr_commit_q) && (w_occ < 2'd2);

    sdp_ram #(
        .WIDTH ($bits(axis_beat_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (w_wr_beat),
        .rd_en_i   (w_fetch),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (w_rd_data)
    );

    assign w_rd_beat = axis_beat_t'(w_rd_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            ram_vld_q  <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            ram_vld_q <= w_fetch;
            if (w_fetch) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (!out_vld_q || w_pop) begin
                if (skid_vld_q) begin
                    out_q      <= skid_q;
                    out_vld_q  <= 1'b1;
                    skid_q     <= w_rd_beat;
                    skid_vld_q <= ram_vld_q;
                end else if (ram_vld_q) begin
                    out_q     <= w_rd_beat;
                    out_vld_q <= 1'b1;
                end else begin
                    out_vld_q <= 1'b0;
                end
            end else if (ram_vld_q) begin
                skid_q     <= w_rd_beat;
                skid_vld_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
        end else begin
            case ({w_commit, w_pop && out_q.tlast})
                2'b10:   frame_count_q <= frame_count_q + 1'b1;
                2'b01:   frame_count_q <= frame_count_q - 1'b1;
                default: frame_count_q <= frame_count_q;
            endcase
        end
    end

    assign s_axis_tready = !reset;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_q.tdata;
    assign m_axis_tlast  = out_q.tlast;
    assign frame_count   = frame_count_q;
    assign drop_pulse    = drop_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_tx_frame_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_tx_frame_fifo: scoreboard bench for axis_tx_frame_fifo.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_axis_tx_frame_fifo;

    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_last;
    logic          m_ready;
    logic [PW-1:0] fc;
    logic          drop;

    int            tests = 0;
    int            fails = 0;
    int            drops = 0;
    int            exp_drops = 0;
    int            rdy_mode = 1;
    logic [8:0]    exp_q[$];
    logic          prev_hold = 1'b0;
    logic [8:0]    prev_beat = 9'h0;

    always #5 clk = ~clk;

    axis_tx_frame_fifo #(
        .DEPTH   (2048),
        .MAX_LEN (1500)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .frame_count   (fc),
        .drop_pulse    (drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // MAC ready: 0 = stalled, 1 = always ready, 2 = random.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'({m_last, m_data}), 32'(prev_beat));
            end
            if (drop) drops++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: actual %0h required none", {m_last, m_data});
                end else begin
                    check("beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_beat = {m_last, m_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input bit keep);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        if (keep) exp_q.push_back({last, d});
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int base, input bit keep);
        for (int i = 0; i < len; i++) begin
            send_byte(8'(base + i), (i == len - 1), keep);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int    hs, first, last, cyc, len;

        idle(3);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_fc", 32'(fc), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        reset = 1'b0;
        tick();

        // Latency, contiguity and frame_count of a short frame
        s = "HE11O WORLD";
        check("t1_fc0", 32'(fc), 32'd0);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], (i == s.len() - 1), 1'b1);
        check("t1_fc1", 32'(fc), 32'd1);
        check("t1_valid_k", 32'(m_valid), 32'd0);
        tick();
        check("t1_valid_k1", 32'(m_valid), 32'd0);
        tick();
        for (int i = 0; i < 11; i++) begin
            check("t1_contig", 32'(m_valid), 32'd1);
            tick();
        end
        check("t1_valid_end", 32'(m_valid), 32'd0);
        check("t1_fc_end", 32'(fc), 32'd0);
        check("t1_q", 32'(exp_q.size()), 32'd0);

        // Three frames buffered while stalled, then a gap-free drain
        rdy_mode = 0;
        tick();
        send_frame(64, 8'h10, 1'b1);
        send_frame(64, 8'h50, 1'b1);
        send_frame(64, 8'h90, 1'b1);
        idle(6);
        check("t2_fc3", 32'(fc), 32'd3);
        check("t2_valid", 32'(m_valid), 32'd1);
        rdy_mode = 1;
        hs = 0; first = -1; last = 0; cyc = 0;
        while (hs < 192 && cyc < 400) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                hs++;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        check("t2_beats", 32'(hs), 32'd192);
        check("t2_span", 32'(last - first), 32'd191);
        idle(2);
        check("t2_fc0", 32'(fc), 32'd0);
        wait_drain(10);

        // Length limit: 1501 and 1600 dropped, 1500 passes
        send_frame(1501, 0, 1'b0);
        exp_drops++;
        check("t3_pulse_hi", 32'(drop), 32'd1);
        tick();
        check("t3_pulse_lo", 32'(drop), 32'd0);
        idle(3);
        check("t3_fc_after_drop", 32'(fc), 32'd0);
        check("t3_valid_after_drop", 32'(m_valid), 32'd0);
        send_frame(1600, 8'h33, 1'b0);
        exp_drops++;
        idle(3);
        check("t3_drops", 32'(drops), 32'(exp_drops));
        send_frame(1500, 8'h07, 1'b1);
        wait_drain(3000);
        check("t3_fc_end", 32'(fc), 32'd0);

        // Buffer overflow: 1000+1000+48 fit while stalled, 3 more bytes do not
        rdy_mode = 0;
        tick();
        send_frame(1000, 8'h20, 1'b1);
        idle(5);
        send_frame(1000, 8'h40, 1'b1);
        idle(5);
        send_frame(48, 8'h60, 1'b1);
        idle(5);
        check("t4_fc3", 32'(fc), 32'd3);
        send_frame(3, 8'h70, 1'b0);
        exp_drops++;
        check("t4_pulse", 32'(drop), 32'd1);
        idle(3);
        check("t4_drops", 32'(drops), 32'(exp_drops));
        check("t4_fc3_after", 32'(fc), 32'd3);
        rdy_mode = 1;
        wait_drain(3000);
        check("t4_fc_end", 32'(fc), 32'd0);

        // Random MAC backpressure across 50 frames
        rdy_mode = 2;
        for (int f = 0; f < 50; f++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) send_byte(8'($urandom), (i == len - 1), 1'b1);
            idle($urandom_range(0, 3));
        end
        wait_drain(8000);
        rdy_mode = 1;
        idle(2);
        check("t5_fc_end", 32'(fc), 32'd0);
        check("t5_drops", 32'(drops), 32'(exp_drops));

        // Reset while a frame is being read and another is being written
        send_frame(20, 8'h80, 1'b1);
        idle(4);
        for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("t6_s_ready_rst", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("t6_valid", 32'(m_valid), 32'd0);
        check("t6_fc", 32'(fc), 32'd0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA7 + i), (i == 4), 1'b1);
        send_frame(25, 8'hC0, 1'b1);
        wait_drain(200);
        check("t6_fc_end", 32'(fc), 32'd0);
        check("t6_drops", 32'(drops), 32'(exp_drops));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
